// File: rtl/ex_mem_pipe_if.sv
// EX->MEM stage bundle: EX-side results/control in, registered MEM-side view out.
// Master is the EX/hazard side that drives stall/flush and ex_*; slave is the pipe register.
interface ex_mem_pipe_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
);
  logic          stall;
  logic          flush;
  logic          ex_valid;
  logic [2:0]    ex_M;
  logic [1:0]    ex_WB;
  logic [2:0]    ex_bcond;
  logic [2:0]    ex_flags;
  logic [2:0]    ex_flag_we;
  logic [DW-1:0] ex_alu;
  logic [DW-1:0] ex_wdata;
  logic [DW-1:0] ex_pcbranch;
  logic [RW-1:0] ex_rd;

  logic          mem_valid;
  logic [2:0]    mem_M;
  logic [1:0]    mem_WB;
  logic [2:0]    mem_bcond;
  logic [2:0]    mem_flags;
  logic [DW-1:0] mem_alu;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_pcbranch;
  logic [RW-1:0] mem_rd;
  logic [CW-1:0] instr_cnt;

  modport master (
    output stall, flush, ex_valid, ex_M, ex_WB, ex_bcond, ex_flags, ex_flag_we,
           ex_alu, ex_wdata, ex_pcbranch, ex_rd,
    input  mem_valid, mem_M, mem_WB, mem_bcond, mem_flags, mem_alu, mem_wdata,
           mem_pcbranch, mem_rd, instr_cnt
  );

  modport slave (
    input  stall, flush, ex_valid, ex_M, ex_WB, ex_bcond, ex_flags, ex_flag_we,
           ex_alu, ex_wdata, ex_pcbranch, ex_rd,
    output mem_valid, mem_M, mem_WB, mem_bcond, mem_flags, mem_alu, mem_wdata,
           mem_pcbranch, mem_rd, instr_cnt
  );
endinterface

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall/flush, architectural {zr,neg,ov} flags and a
// saturating count of real instructions entering MEM. Latency 1; priority flush > stall > load.
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_pipe_if.slave bus
);

  logic          valid_q, valid_d;
  logic [2:0]    m_q, m_d;
  logic [1:0]    wb_q, wb_d;
  logic [2:0]    bcond_q, bcond_d;
  logic [2:0]    flags_q, flags_d;
  logic [DW-1:0] alu_q, alu_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] pcb_q, pcb_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    m_d     = m_q;
    wb_d    = wb_q;
    bcond_d = bcond_q;
    flags_d = flags_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    pcb_d   = pcb_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;

    // Data fields follow EX whenever the stage is not frozen; a flush overrides a stall.
    if (bus.flush || !bus.stall) begin
      bcond_d = bus.ex_bcond;
      alu_d   = bus.ex_alu;
      wdata_d = bus.ex_wdata;
      pcb_d   = bus.ex_pcbranch;
      rd_d    = bus.ex_rd;
      valid_d = 1'b0;
      m_d     = 3'b000;
      wb_d    = 2'b00;
      if (!bus.flush && bus.ex_valid) begin
        valid_d = 1'b1;
        m_d     = bus.ex_M;
        wb_d    = bus.ex_WB;
        flags_d = (flags_q & ~bus.ex_flag_we) | (bus.ex_flags & bus.ex_flag_we);
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      m_q     <= 3'b000;
      wb_q    <= 2'b00;
      bcond_q <= 3'b000;
      flags_q <= 3'b000;
      alu_q   <= '0;
      wdata_q <= '0;
      pcb_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      m_q     <= m_d;
      wb_q    <= wb_d;
      bcond_q <= bcond_d;
      flags_q <= flags_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      pcb_q   <= pcb_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_valid    = valid_q;
  assign bus.mem_M        = m_q;
  assign bus.mem_WB       = wb_q;
  assign bus.mem_bcond    = bcond_q;
  assign bus.mem_flags    = flags_q;
  assign bus.mem_alu      = alu_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_pcbranch = pcb_q;
  assign bus.mem_rd       = rd_q;
  assign bus.instr_cnt    = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe (CW=4 so counter saturation is reachable): vector table with a
// scoreboard queue, followed by hand sequences for stall, saturation and async reset.
module tb_ex_mem_pipe;

  localparam int DW = 16;
  localparam int RW = 4;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ex_mem_pipe_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

  ex_mem_pipe #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fl;
    logic        v;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [2:0]  f;
    logic [2:0]  we;
    logic [15:0] alu;
    logic [3:0]  rd;
    logic        ev;
    logic [2:0]  em;
    logic [1:0]  ewb;
    logic [2:0]  ef;
    logic [3:0]  ecnt;
    logic [15:0] ealu;
    logic [3:0]  erd;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [2:0]  em;
    logic [1:0]  ewb;
    logic [2:0]  ef;
    logic [3:0]  ecnt;
    logic [15:0] ealu;
    logic [3:0]  erd;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [2:0] m,
                       input logic [1:0] wb, input logic [2:0] bc, input logic [2:0] f,
                       input logic [2:0] we, input logic [15:0] alu, input logic [15:0] wd,
                       input logic [15:0] pcb, input logic [3:0] rd);
    bus.stall       = st;
    bus.flush       = fl;
    bus.ex_valid    = v;
    bus.ex_M        = m;
    bus.ex_WB       = wb;
    bus.ex_bcond    = bc;
    bus.ex_flags    = f;
    bus.ex_flag_we  = we;
    bus.ex_alu      = alu;
    bus.ex_wdata    = wd;
    bus.ex_pcbranch = pcb;
    bus.ex_rd       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   cnt_m;
    n_tests = 0;
    n_fail  = 0;

    //            st fl v  M       WB     flags   we      alu       rd     ev M      WB     flags   cnt  alu       rd
    vecs[0] = '{1'b0,1'b0,1'b1,3'b010,2'b00,3'b000,3'b000,16'hBEEF,4'h5, 1'b1,3'b010,2'b00,3'b000,4'd1,16'hBEEF,4'h5};
    vecs[1] = '{1'b0,1'b0,1'b1,3'b000,2'b11,3'b101,3'b111,16'h0001,4'h1, 1'b1,3'b000,2'b11,3'b101,4'd2,16'h0001,4'h1};
    vecs[2] = '{1'b0,1'b0,1'b1,3'b000,2'b01,3'b010,3'b010,16'h0002,4'h2, 1'b1,3'b000,2'b01,3'b111,4'd3,16'h0002,4'h2};
    vecs[3] = '{1'b0,1'b0,1'b1,3'b000,2'b01,3'b000,3'b000,16'h0003,4'h3, 1'b1,3'b000,2'b01,3'b111,4'd4,16'h0003,4'h3};
    vecs[4] = '{1'b0,1'b0,1'b0,3'b111,2'b11,3'b000,3'b111,16'h0004,4'h4, 1'b0,3'b000,2'b00,3'b111,4'd4,16'h0004,4'h4};
    vecs[5] = '{1'b1,1'b0,1'b1,3'b100,2'b10,3'b000,3'b111,16'h0005,4'h6, 1'b0,3'b000,2'b00,3'b111,4'd4,16'h0004,4'h4};
    vecs[6] = '{1'b0,1'b1,1'b1,3'b100,2'b11,3'b000,3'b111,16'h0006,4'h7, 1'b0,3'b000,2'b00,3'b111,4'd4,16'h0006,4'h7};
    vecs[7] = '{1'b1,1'b1,1'b1,3'b001,2'b11,3'b000,3'b111,16'h0007,4'h8, 1'b0,3'b000,2'b00,3'b111,4'd4,16'h0007,4'h8};
    vecs[8] = '{1'b0,1'b0,1'b1,3'b100,2'b00,3'b010,3'b101,16'h0008,4'h9, 1'b1,3'b100,2'b00,3'b010,4'd5,16'h0008,4'h9};
    vecs[9] = '{1'b1,1'b0,1'b1,3'b010,2'b11,3'b101,3'b111,16'h0009,4'hA, 1'b1,3'b100,2'b00,3'b010,4'd5,16'h0008,4'h9};

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 3'd0, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 4'h0);
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("reset_M",     {29'd0, bus.mem_M},     32'd0);
    chk("reset_WB",    {30'd0, bus.mem_WB},    32'd0);
    chk("reset_flags", {29'd0, bus.mem_flags}, 32'd0);
    chk("reset_cnt",   {28'd0, bus.instr_cnt}, 32'd0);
    rst = 1'b1;

    // Table: drive on the falling edge, push expectation, compare after the rising edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].m, vecs[i].wb, 3'd0, vecs[i].f,
            vecs[i].we, vecs[i].alu, 16'h0, 16'h0, vecs[i].rd);
      sbq.push_back('{vecs[i].ev, vecs[i].em, vecs[i].ewb, vecs[i].ef, vecs[i].ecnt,
                      vecs[i].ealu, vecs[i].erd});
      step();
      e = sbq.pop_front();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.mem_valid}, {31'd0, e.ev});
      chk($sformatf("v%0d_M", i),     {29'd0, bus.mem_M},     {29'd0, e.em});
      chk($sformatf("v%0d_WB", i),    {30'd0, bus.mem_WB},    {30'd0, e.ewb});
      chk($sformatf("v%0d_flags", i), {29'd0, bus.mem_flags}, {29'd0, e.ef});
      chk($sformatf("v%0d_cnt", i),   {28'd0, bus.instr_cnt}, {28'd0, e.ecnt});
      chk($sformatf("v%0d_alu", i),   {16'd0, bus.mem_alu},   {16'd0, e.ealu});
      chk($sformatf("v%0d_rd", i),    {28'd0, bus.mem_rd},    {28'd0, e.erd});
    end

    // Full-field load: wdata, pcbranch, bcond travel with the instruction.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'b100, 2'b10, 3'd5, 3'b000, 3'b000, 16'h4321, 16'h5555, 16'hABCD, 4'hC);
    step();
    chk("load_wdata", {16'd0, bus.mem_wdata},    32'h5555);
    chk("load_pcb",   {16'd0, bus.mem_pcbranch}, 32'hABCD);
    chk("load_bcond", {29'd0, bus.mem_bcond},    32'd5);
    chk("load_cnt",   {28'd0, bus.instr_cnt},    32'd6);

    // Three stalled cycles with changing EX contents: everything frozen.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 3'(i + 1), 2'b01, 3'(i), 3'b111, 3'b111, 16'(16'h1000 + i),
            16'(i), 16'(i), 4'(i));
      step();
      chk($sformatf("stall%0d_alu", i),   {16'd0, bus.mem_alu},      32'h4321);
      chk($sformatf("stall%0d_wdata", i), {16'd0, bus.mem_wdata},    32'h5555);
      chk($sformatf("stall%0d_M", i),     {29'd0, bus.mem_M},        32'b100);
      chk($sformatf("stall%0d_flags", i), {29'd0, bus.mem_flags},    32'b010);
      chk($sformatf("stall%0d_cnt", i),   {28'd0, bus.instr_cnt},    32'd6);
    end

    // Saturation: 20 consecutive valid loads on a 4-bit counter starting at 6.
    cnt_m = 6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 3'd0, 3'b000, 3'b000, 16'(i), 16'h0, 16'h0, 4'h1);
      step();
      if (cnt_m < 15) cnt_m++;
      chk($sformatf("sat%0d_cnt", i), {28'd0, bus.instr_cnt}, 32'(cnt_m));
    end

    // Reset asserted between edges must clear outputs without a clock edge.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'b001, 2'b11, 3'd3, 3'b111, 3'b111, 16'h1234, 16'h7777, 16'h8888, 4'hE);
    step();
    chk("pre_rst_alu",   {16'd0, bus.mem_alu},   32'h1234);
    chk("pre_rst_flags", {29'd0, bus.mem_flags}, 32'b111);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.mem_valid},    32'd0);
    chk("arst_M",     {29'd0, bus.mem_M},        32'd0);
    chk("arst_WB",    {30'd0, bus.mem_WB},       32'd0);
    chk("arst_flags", {29'd0, bus.mem_flags},    32'd0);
    chk("arst_cnt",   {28'd0, bus.instr_cnt},    32'd0);
    chk("arst_alu",   {16'd0, bus.mem_alu},      32'd0);
    chk("arst_wdata", {16'd0, bus.mem_wdata},    32'd0);
    chk("arst_pcb",   {16'd0, bus.mem_pcbranch}, 32'd0);
    chk("arst_rd",    {28'd0, bus.mem_rd},       32'd0);
    chk("arst_bcond", {29'd0, bus.mem_bcond},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
